bb8_sequencer: RTL and testbench

//  Instruction sequencer for the ByteBlast8 core; replaces the free-running fde + mux4 pairing.

---
 rtl/bb8_sequencer.sv | 118 +++++++++++
 tb/tb_bb8_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bb8_sequencer.sv
// bb8_sequencer: instruction sequencer for the ByteBlast8 core.
// Owns the single RAM port and holds PC, instruction register, accumulator
// and carry. Instruction byte = {opcode[2:0], operand address}.
// RAM handshake: the address is presented combinationally from state and
// the RAM returns the word on ram_data_in one clock later; a write happens
// on the rising edge while ram_w_enable is high.
module bb8_sequencer #(
    parameter int ADDRESS_BITS = 5,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic [ADDRESS_BITS-1:0] ram_address,
    input  logic [DATA_BITS-1:0]    ram_data_in,
    output logic                    ram_w_enable,
    output logic [DATA_BITS-1:0]    ram_data_out,
    output logic [ADDRESS_BITS-1:0] pc_out,
    output logic [DATA_BITS-1:0]    acc_out,
    output logic                    carry,
    output logic                    halted,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LATCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_STR = 3'b100;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [ADDRESS_BITS-1:0] PC_ONE = ADDRESS_BITS'(1);

    state_t                  r_state;
    logic [ADDRESS_BITS-1:0] r_pc;
    logic [DATA_BITS-1:0]    r_ir;
    logic [DATA_BITS-1:0]    r_acc;
    logic                    r_carry;

    logic [2:0]              w_opcode;
    logic [ADDRESS_BITS-1:0] w_operand;
    logic [DATA_BITS:0]      w_sum;

    assign w_opcode  = r_ir[DATA_BITS-1:DATA_BITS-3];
    assign w_operand = r_ir[ADDRESS_BITS-1:0];
    assign w_sum     = {1'b0, r_acc} + {1'b0, ram_data_in};

    // Sequencer FSM plus PC/IR/ACC/carry; reset wins over enable, enable=0 freezes all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (enable) begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_ir    <= ram_data_in;
                    r_pc    <= r_pc + PC_ONE;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (w_opcode)
                        OP_HLT:         r_state <= S_HALT;
                        OP_LD, OP_ADD:  r_state <= S_EXEC;
                        default:        r_state <= S_FETCH;
                    endcase
                end
                S_EXEC: begin
                    if (w_opcode == OP_LD) begin
                        r_acc   <= ram_data_in;
                        r_carry <= 1'b0;
                    end else if (w_opcode == OP_ADD) begin
                        {r_carry, r_acc} <= w_sum;
                    end
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // RAM port steering: operand address while decoding/executing, PC otherwise.
    // The store strobe is suppressed when frozen or when reset is being applied.
    always_comb begin
        ram_address  = r_pc;
        ram_w_enable = 1'b0;
        if (r_state == S_DECODE || r_state == S_EXEC) begin
            ram_address = w_operand;
        end
        if (r_state == S_DECODE && w_opcode == OP_STR && enable && reset) begin
            ram_w_enable = 1'b1;
        end
    end

    assign ram_data_out = r_acc;
    assign pc_out       = r_pc;
    assign acc_out      = r_acc;
    assign carry        = r_carry;
    assign halted       = (r_state == S_HALT);
    assign state        = r_state;

endmodule

// File: tb/tb_bb8_sequencer.sv
// tb_bb8_sequencer: bench for bb8_sequencer with a synchronous-read RAM,
// an instruction-level reference model and directed plus random programs.
module tb_bb8_sequencer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [4:0] ram_address;
    logic [7:0] ram_data_in;
    logic       ram_w_enable;
    logic [7:0] ram_data_out;
    logic [4:0] pc_out;
    logic [7:0] acc_out;
    logic       carry;
    logic       halted;
    logic [2:0] state;

    bb8_sequencer #(.ADDRESS_BITS(5), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_w_enable(ram_w_enable),
        .ram_data_out(ram_data_out),
        .pc_out      (pc_out),
        .acc_out     (acc_out),
        .carry       (carry),
        .halted      (halted),
        .state       (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_writes = 0;
    logic chk_en;
    logic ram_load;
    logic [7:0] img [32];
    logic [7:0] ram [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // environment RAM: synchronous read, write on strobe, bulk load from img
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 32; i++) ram[i] <= img[i];
        end else if (ram_w_enable) begin
            ram[ram_address] <= ram_data_out;
        end
        ram_data_in <= ram[ram_address];
    end

    always @(posedge clk) if (ram_w_enable) n_writes <= n_writes + 1;

    // ---------------- reference model (instruction-level timeline) ----------
    // Each instruction occupies a fixed number of cycles: LD/ADD 4, others 3.
    // Cycle 1 of an instruction fetches it and bumps PC, cycle 2 may store or
    // halt, and the last cycle applies the accumulator effect.
    logic [7:0] m_mem [32];
    logic [4:0] m_pc;
    logic [7:0] m_acc;
    logic [7:0] m_ir;
    logic       m_carry;
    logic       m_halted;
    int         m_off;

    always @(posedge clk) begin
        logic [2:0] op;
        logic [4:0] opnd;
        logic [8:0] s;
        int lat;
        if (ram_load) m_mem = img;
        if (!reset) begin
            m_pc = 0; m_acc = 0; m_ir = 0; m_carry = 0; m_halted = 0; m_off = 0;
        end else if (enable && !m_halted) begin
            op   = m_ir[7:5];
            opnd = m_ir[4:0];
            lat  = (op == 3'b001 || op == 3'b010) ? 4 : 3;
            if (m_off == 0) begin
                m_off = 1;
            end else if (m_off == 1) begin
                m_ir  = m_mem[m_pc];
                m_pc  = m_pc + 5'd1;
                m_off = 2;
            end else if (m_off == 2 && op == 3'b111) begin
                m_halted = 1;
            end else begin
                if (m_off == 2 && op == 3'b100) m_mem[opnd] = m_acc;
                if (m_off == lat - 1) begin
                    if (op == 3'b001) begin
                        m_acc = m_mem[opnd];
                        m_carry = 0;
                    end else if (op == 3'b010) begin
                        s = {1'b0, m_acc} + {1'b0, m_mem[opnd]};
                        m_acc = s[7:0];
                        m_carry = s[8];
                    end
                    m_off = 0;
                end else begin
                    m_off = m_off + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model -------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", state, m_halted ? 3'd4 : 3'(m_off));
            chk("pc_out", pc_out, m_pc);
            chk("acc_out", acc_out, m_acc);
            chk("ram_data_out", ram_data_out, m_acc);
            chk("carry", carry, m_carry);
            chk("halted", halted, m_halted);
            chk("ram_w_enable", ram_w_enable,
                !m_halted && m_off == 2 && m_ir[7:5] == 3'b100 && enable && reset);
            if (m_halted || m_off == 0)
                chk("ram_address_pc", ram_address, m_pc);
            else if (m_off >= 2)
                chk("ram_address_opnd", ram_address, m_ir[4:0]);
        end
    end

    // ---------------- driver tasks ------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [7:0] d6, input logic [7:0] d7);
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        img[0] = 8'h26; img[1] = 8'h47; img[2] = 8'h88; img[3] = 8'hE0;
        img[6] = d6;    img[7] = d7;
    endtask

    // one reset edge that also loads RAM from img; leaves reset released
    task automatic do_reset();
        reset = 1'b0; enable = 1'b1; ram_load = 1'b1;
        tick(1);
        ram_load = 1'b0; reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        int w0;
        reset = 1'b0; enable = 1'b1; ram_load = 1'b0; chk_en = 1'b0;
        tick(2);

        // basic program: LD 6, ADD 7, STR 8, HLT
        load_prog(8'd2, 8'd5);
        do_reset();
        chk_en = 1'b1;
        chk("t1_reset_state", state, 0);
        chk("t1_reset_pc", pc_out, 0);
        tick(13);
        chk("t1_not_halted_c13", halted, 0);
        tick(1);
        chk("t1_halted_c14", halted, 1);
        chk("t1_pc", pc_out, 4);
        chk("t1_acc", acc_out, 7);
        chk("t1_carry", carry, 0);
        chk("t1_ram8", ram[8], 7);
        tick(3);
        chk("t1_stays_halted", halted, 1);

        // reset with enable low still clears halt
        enable = 1'b0; reset = 1'b0;
        tick(1);
        chk("t6_halted_cleared", halted, 0);
        chk("t6_state_fetch", state, 0);
        reset = 1'b1; enable = 1'b1;

        // carry out of ADD
        load_prog(8'hF0, 8'h20);
        do_reset();
        tick(14);
        chk("t2_acc", acc_out, 8'h10);
        chk("t2_carry", carry, 1);
        chk("t2_ram8", ram[8], 8'h10);
        // same, followed by LD 8 which clears carry
        img[3] = 8'h28; img[4] = 8'hE0;
        do_reset();
        tick(18);
        chk("t2b_halted", halted, 1);
        chk("t2b_acc", acc_out, 8'h10);
        chk("t2b_carry_cleared", carry, 0);

        // stall during EXEC of ADD
        load_prog(8'd2, 8'd5);
        do_reset();
        tick(7);
        chk("t3_in_exec", state, 3);
        enable = 1'b0;
        tick(5);
        chk("t3_state_frozen", state, 3);
        chk("t3_pc_frozen", pc_out, 2);
        chk("t3_acc_frozen", acc_out, 2);
        enable = 1'b1;
        tick(7);
        chk("t3_halted", halted, 1);
        chk("t3_acc", acc_out, 7);
        chk("t3_ram8", ram[8], 7);

        // reset during DECODE of STR
        do_reset();
        tick(10);
        chk("t4_in_decode", state, 2);
        reset = 1'b0;
        #1;
        chk("t4_no_write", ram_w_enable, 0);
        tick(1);
        chk("t4_state", state, 0);
        chk("t4_pc", pc_out, 0);
        chk("t4_acc", acc_out, 0);
        chk("t4_ram8_kept", ram[8], 0);
        reset = 1'b1;
        tick(14);
        chk("t4_rerun_ram8", ram[8], 7);

        // all-NOP memory: PC walks and wraps, never writes
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        do_reset();
        w0 = n_writes;
        tick(94);
        chk("t5_pc_31", pc_out, 31);
        tick(1);
        chk("t5_pc_wrap", pc_out, 0);
        tick(3);
        chk("t5_pc_1", pc_out, 1);
        chk("t5_no_writes", n_writes, w0);

        // random programs, random stalls and occasional resets
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
            do_reset();
            repeat (300) begin
                enable = ($urandom_range(0, 9) != 0);
                reset  = ($urandom_range(0, 99) != 0);
                tick(1);
            end
            reset = 1'b1; enable = 1'b1;
        end

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
